// File: rtl/servo_drive_ctrl.sv
// servo_drive_ctrl
//   Two-wheel continuous-servo drive controller. Decodes drive commands in a
//   five-state FSM and produces period-aligned servo pulses for both wheels.
//   Width changes are ramped and applied only at the frame boundary, turns are
//   timed in frames, and an obstacle forces an immediate stop.
//
// Ports
//   clk        in  system clock, rising edge
//   rst_n      in  asynchronous active-low reset
//   forward    in  drive straight while high
//   turnLeft   in  request timed spin-left
//   turnRight  in  request timed spin-right
//   tooClose   in  obstacle detected, forces stop
//   pulseLeft  out left servo pulse (registered)
//   pulseRight out right servo pulse (registered)
//   turning    out high in TURN_L / TURN_R
//   blocked    out high in BLOCKED
//
// state     | meaning
// S_IDLE    | both wheels ramp to neutral, accepts commands
// S_FWD     | drive straight ahead
// S_TURN_L  | timed spin-left, commands other than tooClose ignored
// S_TURN_R  | timed spin-right, commands other than tooClose ignored
// S_BLOCKED | obstacle, widths forced to neutral at next frame boundary

module servo_drive_ctrl #(
    parameter int PERIOD_CYCLES  = 1_000_000,
    parameter int NEUTRAL_CYCLES = 75_000,
    parameter int SPAN_CYCLES    = 25_000,
    parameter int RAMP_STEP      = 2_500,
    parameter int TURN_FRAMES    = 50,
    parameter int CNT_W          = 20,
    parameter int TURN_W         = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic forward,
    input  logic turnLeft,
    input  logic turnRight,
    input  logic tooClose,
    output logic pulseLeft,
    output logic pulseRight,
    output logic turning,
    output logic blocked
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FWD,
        S_TURN_L,
        S_TURN_R,
        S_BLOCKED
    } state_t;

    localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [CNT_W:0]      W_NEU     = (CNT_W+1)'(NEUTRAL_CYCLES);
    localparam logic [CNT_W:0]      W_HI      = (CNT_W+1)'(NEUTRAL_CYCLES + SPAN_CYCLES);
    localparam logic [CNT_W:0]      W_LO      = (CNT_W+1)'(NEUTRAL_CYCLES - SPAN_CYCLES);
    localparam logic [CNT_W:0]      STEP_U    = (CNT_W+1)'(RAMP_STEP);
    localparam logic signed [CNT_W:0] STEP_S  = $signed(STEP_U);
    // A zero-frame turn still lasts through one frame boundary.
    localparam logic [TURN_W-1:0]   TURN_LOAD = (TURN_FRAMES == 0) ? TURN_W'(1) : TURN_W'(TURN_FRAMES);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W:0]      width_l_q, width_l_d;
    logic [CNT_W:0]      width_r_q, width_r_d;
    logic [TURN_W-1:0]   turn_cnt_q, turn_cnt_d;
    logic                pulse_l_q, pulse_l_d;
    logic                pulse_r_q, pulse_r_d;
    logic                fb;
    logic                in_turn;
    logic [CNT_W:0]      tgt_l, tgt_r;

    // Move cur toward tgt by at most RAMP_STEP. Widths are below 2^CNT_W, so
    // the CNT_W+1 bit signed difference cannot wrap.
    function automatic logic [CNT_W:0] ramp(input logic [CNT_W:0] cur, input logic [CNT_W:0] tgt);
        logic signed [CNT_W:0] diff;
        diff = $signed(tgt) - $signed(cur);
        if (diff > STEP_S)
            ramp = cur + STEP_U;
        else if (diff < -STEP_S)
            ramp = cur - STEP_U;
        else
            ramp = tgt;
    endfunction

    always_comb begin
        fb      = (cnt_q == CNT_LAST);
        in_turn = (state_q == S_TURN_L) || (state_q == S_TURN_R);
        cnt_d   = fb ? '0 : cnt_q + CNT_W'(1);

        state_d = state_q;
        if (tooClose) begin
            state_d = S_BLOCKED;
        end else begin
            case (state_q)
                S_IDLE, S_FWD: begin
                    if (turnLeft)       state_d = S_TURN_L;
                    else if (turnRight) state_d = S_TURN_R;
                    else if (forward)   state_d = S_FWD;
                    else                state_d = S_IDLE;
                end
                S_TURN_L, S_TURN_R: begin
                    if (fb && (turn_cnt_q == TURN_W'(1))) state_d = S_IDLE;
                end
                S_BLOCKED: state_d = S_IDLE;
                default:   state_d = S_IDLE;
            endcase
        end

        turn_cnt_d = turn_cnt_q;
        if (!in_turn && ((state_d == S_TURN_L) || (state_d == S_TURN_R)))
            turn_cnt_d = TURN_LOAD;
        else if (in_turn && fb)
            turn_cnt_d = turn_cnt_q - TURN_W'(1);

        case (state_q)
            S_FWD:    begin tgt_l = W_HI; tgt_r = W_LO; end
            S_TURN_L: begin tgt_l = W_LO; tgt_r = W_LO; end
            S_TURN_R: begin tgt_l = W_HI; tgt_r = W_HI; end
            default:  begin tgt_l = W_NEU; tgt_r = W_NEU; end
        endcase

        // Widths only move at the frame boundary so no pulse is cut or stretched.
        width_l_d = width_l_q;
        width_r_d = width_r_q;
        if (fb) begin
            if (state_q == S_BLOCKED) begin
                width_l_d = W_NEU;
                width_r_d = W_NEU;
            end else begin
                width_l_d = ramp(width_l_q, tgt_l);
                width_r_d = ramp(width_r_q, tgt_r);
            end
        end

        pulse_l_d = ({1'b0, cnt_q} < width_l_q);
        pulse_r_d = ({1'b0, cnt_q} < width_r_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            width_l_q  <= W_NEU;
            width_r_q  <= W_NEU;
            turn_cnt_q <= '0;
            pulse_l_q  <= 1'b0;
            pulse_r_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            width_l_q  <= width_l_d;
            width_r_q  <= width_r_d;
            turn_cnt_q <= turn_cnt_d;
            pulse_l_q  <= pulse_l_d;
            pulse_r_q  <= pulse_r_d;
        end
    end

    assign pulseLeft  = pulse_l_q;
    assign pulseRight = pulse_r_q;
    assign turning    = in_turn;
    assign blocked    = (state_q == S_BLOCKED);

endmodule

// File: tb/tb_servo_drive_ctrl.sv
// Testbench for servo_drive_ctrl at reduced scale (period 100, neutral 30,
// span 10, ramp 4, 3-frame turns). A frame-level reference model predicts
// every output each cycle; measured pulse widths per frame are also compared
// against the expected sequences directly.

module tb_servo_drive_ctrl;

    localparam int P  = 100;
    localparam int N  = 30;
    localparam int S  = 10;
    localparam int R  = 4;
    localparam int TF = 3;

    localparam int M_IDLE = 0;
    localparam int M_FWD  = 1;
    localparam int M_TL   = 2;
    localparam int M_TR   = 3;
    localparam int M_BLK  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic forward = 1'b0;
    logic turnLeft = 1'b0;
    logic turnRight = 1'b0;
    logic tooClose = 1'b0;
    logic pulseLeft, pulseRight, turning, blocked;

    int total = 0;
    int bad = 0;

    // reference model state
    int m_pos, m_wl, m_wr, m_mode, m_left;
    logic m_pl, m_pr;
    int hi_l, hi_r, frame_wl, frame_wr;

    always #5 clk = ~clk;

    servo_drive_ctrl #(
        .PERIOD_CYCLES (P),
        .NEUTRAL_CYCLES(N),
        .SPAN_CYCLES   (S),
        .RAMP_STEP     (R),
        .TURN_FRAMES   (TF),
        .CNT_W         (7),
        .TURN_W        (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .forward   (forward),
        .turnLeft  (turnLeft),
        .turnRight (turnRight),
        .tooClose  (tooClose),
        .pulseLeft (pulseLeft),
        .pulseRight(pulseRight),
        .turning   (turning),
        .blocked   (blocked)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int toward(input int cur, input int tgt);
        int d, mag, step;
        d    = tgt - cur;
        mag  = (d < 0) ? -d : d;
        step = (mag < R) ? mag : R;
        return (d < 0) ? cur - step : cur + step;
    endfunction

    task automatic model_reset();
        m_pos = 0; m_wl = N; m_wr = N; m_mode = M_IDLE; m_left = 0;
        m_pl = 1'b0; m_pr = 1'b0; hi_l = 0; hi_r = 0;
    endtask

    task automatic model_edge();
        bit fb;
        int tl, tr;
        fb   = (m_pos == P - 1);
        m_pl = (m_pos < m_wl);
        m_pr = (m_pos < m_wr);
        if (fb) begin
            case (m_mode)
                M_FWD:   begin tl = N + S; tr = N - S; end
                M_TL:    begin tl = N - S; tr = N - S; end
                M_TR:    begin tl = N + S; tr = N + S; end
                default: begin tl = N;     tr = N;     end
            endcase
            if (m_mode == M_BLK) begin
                m_wl = N; m_wr = N;
            end else begin
                m_wl = toward(m_wl, tl);
                m_wr = toward(m_wr, tr);
            end
        end
        if (tooClose) begin
            m_mode = M_BLK;
        end else if (m_mode == M_TL || m_mode == M_TR) begin
            if (fb) begin
                m_left = m_left - 1;
                if (m_left == 0) m_mode = M_IDLE;
            end
        end else if (m_mode == M_BLK) begin
            m_mode = M_IDLE;
        end else if (turnLeft) begin
            m_mode = M_TL; m_left = (TF == 0) ? 1 : TF;
        end else if (turnRight) begin
            m_mode = M_TR; m_left = (TF == 0) ? 1 : TF;
        end else if (forward) begin
            m_mode = M_FWD;
        end else begin
            m_mode = M_IDLE;
        end
        m_pos = (m_pos + 1) % P;
    endtask

    // One clock: advance the model on the edge, compare all outputs 1 time
    // unit later, and accumulate measured high time for the current frame.
    task automatic tick();
        int pre;
        @(posedge clk);
        pre = m_pos;
        model_edge();
        #1;
        chk("pulseLeft", pulseLeft, m_pl);
        chk("pulseRight", pulseRight, m_pr);
        chk("turning", turning, (m_mode == M_TL || m_mode == M_TR));
        chk("blocked", blocked, (m_mode == M_BLK));
        if (pre == 0) begin hi_l = 0; hi_r = 0; end
        hi_l += int'(pulseLeft);
        hi_r += int'(pulseRight);
        if (pre == P - 1) begin frame_wl = hi_l; frame_wr = hi_r; end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic align();
        while (m_pos != 0) tick();
    endtask

    task automatic chk_frame(input string tag, input int wl, input int wr);
        chk_int({tag, "_left"}, frame_wl, wl);
        chk_int({tag, "_right"}, frame_wr, wr);
    endtask

    initial begin
        int fwd_l[5] = '{30, 34, 38, 40, 40};
        int fwd_r[5] = '{30, 26, 22, 20, 20};
        int r;

        model_reset();
        #2;
        chk("rst_pulseLeft", pulseLeft, 1'b0);
        chk("rst_pulseRight", pulseRight, 1'b0);
        chk("rst_turning", turning, 1'b0);
        chk("rst_blocked", blocked, 1'b0);
        #10 rst_n = 1'b1;

        // idle frames after reset
        run(P);
        chk_frame("idle0", N, N);
        run(P);
        chk_frame("idle1", N, N);

        // forward ramp, frame aligned
        forward = 1'b1;
        for (int f = 0; f < 5; f++) begin
            run(P);
            chk_frame("fwd", fwd_l[f], fwd_r[f]);
        end

        // obstacle at full speed
        run(50);
        tooClose = 1'b1;
        tick();
        chk("blk_set", blocked, 1'b1);
        run(49);
        run(P);
        chk_frame("blk", N, N);
        tooClose = 1'b0;
        forward = 1'b0;
        tick();
        chk("blk_release", blocked, 1'b0);
        chk("blk_release_turn", turning, 1'b0);

        // both turns together: left wins, forward ignored, abort by tooClose
        run(20);
        turnLeft = 1'b1; turnRight = 1'b1;
        tick();
        turnLeft = 1'b0; turnRight = 1'b0; forward = 1'b1;
        tick();
        chk("both_turning", turning, 1'b1);
        run(150);
        chk("both_still_turning", turning, 1'b1);
        run(60);
        tooClose = 1'b1; forward = 1'b0;
        tick();
        chk("abort_blocked", blocked, 1'b1);
        chk("abort_turning", turning, 1'b0);
        tooClose = 1'b0;
        tick();
        chk("abort_idle", blocked, 1'b0);

        // single-cycle turnLeft from settled idle
        run(4 * P);
        align();
        run(50);
        turnLeft = 1'b1;
        tick();
        turnLeft = 1'b0;
        chk("tl_turning", turning, 1'b1);
        run(49);
        run(P);
        chk_frame("tl1", 26, 26);
        chk("tl_mid_turning", turning, 1'b1);
        run(P);
        chk_frame("tl2", 22, 22);
        chk("tl_done", turning, 1'b0);
        run(P);
        chk_frame("tl3", 20, 20);
        run(P);
        chk_frame("tl4", 24, 24);

        // randomized commands against the model
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 8) forward = ~forward;
            turnLeft  = ($urandom_range(0, 199) == 0);
            turnRight = ($urandom_range(0, 199) == 0);
            if (tooClose) tooClose = ($urandom_range(0, 3) != 0);
            else          tooClose = ($urandom_range(0, 499) == 0);
            tick();
        end
        forward = 1'b0; turnLeft = 1'b0; turnRight = 1'b0; tooClose = 1'b0;
        run(5 * P);

        // reset mid-pulse during TURN_R
        align();
        turnRight = 1'b1;
        tick();
        turnRight = 1'b0;
        run(10);
        chk("tr_turning", turning, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_pulseLeft", pulseLeft, 1'b0);
        chk("midrst_pulseRight", pulseRight, 1'b0);
        chk("midrst_turning", turning, 1'b0);
        chk("midrst_blocked", blocked, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run(P);
        chk_frame("postrst", N, N);
        chk("postrst_turning", turning, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
